// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding, port ids, default widths.
// Pure declarations, no logic and no latency.
// Also provides a helper that maps a port id to its ownership state.
package mem_arb_pkg;

    localparam int ADR_W_DEF     = 6;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic [1:0] own_state(input logic port);
        return (port == PORT_B) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-request round-robin picker with a port-B priority override.
// Purely combinational, zero latency.
// No backpressure: the caller decides when the pick is consumed.
//
// Ports: req_a/req_b requests, last = port id served most recently,
//        prio_b forces B whenever B requests; vld = any request, pick = chosen port id.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic prio_b,
    output logic vld,
    output logic pick
);

    always_comb begin
        vld = req_a | req_b;
        if (prio_b && req_b) begin
            pick = PORT_B;
        end else if (req_a && req_b) begin
            // tie: serve whichever port was not served last
            pick = (last == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            pick = PORT_B;
        end else begin
            pick = PORT_A;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between port A (CPU) and port B (loader/DMA).
// Grant is combinational on the ownership state; a request raised in IDLE is granted next enabled cycle, read data one enabled cycle after the grant.
// Requesters hold req/we/adr/wdata until they see gnt; ce=0 freezes all state and blocks grants.
//
// Ports: clk/rst (sync, active-high)/ce; boot gives port B absolute priority;
//        per port x in {a,b}: x_req, x_lock, x_we, x_adr, x_wdata in; x_gnt, x_rvalid, x_rdata out;
//        memory side: mem_en, mem_we, mem_adr, mem_wdata out; mem_rdata in (one cycle after a read).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADR_W     = ADR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              boot,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic              a_we,
    input  logic [ADR_W-1:0]  a_adr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic              b_we,
    input  logic [ADR_W-1:0]  b_adr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);
    localparam logic [8:0] MAX_B9 = 9'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       last_q, last_d;
    logic       rd_owner_q, rd_owner_d;
    logic       rd_pend_q, rd_pend_d;

    logic       own_a, own_b;
    logic       x_req, x_lock, o_req;
    logic [1:0] other_state;
    logic       burst_room;
    logic       arb_vld, arb_pick;

    assign own_a = (state_q == OWN_A);
    assign own_b = (state_q == OWN_B);

    assign a_gnt  = ce & own_a & a_req;
    assign b_gnt  = ce & own_b & b_req;
    assign mem_en = a_gnt | b_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_adr   = a_adr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_adr   = b_adr;
            mem_wdata = b_wdata;
        end
    end

    // Read data belongs to whoever issued the read, even if ownership has moved on.
    assign a_rvalid = ce & rd_pend_q & (rd_owner_q == PORT_A);
    assign b_rvalid = ce & rd_pend_q & (rd_owner_q == PORT_B);
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

    arb_rr2 u_arb (
        .req_a  (a_req),
        .req_b  (b_req),
        .last   (last_q),
        .prio_b (boot),
        .vld    (arb_vld),
        .pick   (arb_pick)
    );

    // Owner-relative view of the request lines.
    always_comb begin
        x_req       = own_b ? b_req  : a_req;
        x_lock      = own_b ? b_lock : a_lock;
        o_req       = own_b ? a_req  : b_req;
        other_state = own_b ? OWN_A  : OWN_B;
        burst_room  = ({1'b0, burst_cnt_q} + 9'd1) < MAX_B9;
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        rd_owner_d  = rd_owner_q;
        rd_pend_d   = rd_pend_q;
        if (ce) begin
            rd_pend_d = mem_en & ~mem_we;
            if (mem_en) begin
                rd_owner_d = b_gnt ? PORT_B : PORT_A;
                last_d     = b_gnt ? PORT_B : PORT_A;
            end

            if (boot && b_req) begin
                state_d = OWN_B;
            end else if (boot && own_a) begin
                // boot revokes A's ownership regardless of lock or burst budget
                state_d = IDLE;
            end else if (!(own_a || own_b)) begin
                // IDLE (and any unused encoding) arbitrates afresh
                state_d = arb_vld ? own_state(arb_pick) : IDLE;
            end else if (x_req) begin
                // owner was granted: a lock only holds off a waiting port for a bounded burst
                state_d = (!o_req || (x_lock && burst_room)) ? state_q : other_state;
            end else if (o_req) begin
                state_d = own_state(arb_pick);
            end else begin
                state_d = x_lock ? state_q : IDLE;
            end

            if ((state_d != state_q) || (state_d == IDLE)) begin
                burst_cnt_d = '0;
            end else if (mem_en && o_req) begin
                burst_cnt_d = (burst_cnt_q == MAX_B8) ? burst_cnt_q : burst_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= PORT_B;
            rd_owner_q  <= PORT_A;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            rd_owner_q  <= rd_owner_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

endmodule
